// File: rtl/simd_pkg.sv
// Shared opcode encoding and saturation limits for the SIMD lane ALU.
package simd_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MUL = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_MIN = 3'b011,
        OP_MAX = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    // Limits are returned in the low w bits of a 32-bit word; callers truncate.
    function automatic logic [31:0] sat_max(input int w);
        return 32'h7FFF_FFFF >> (32 - w);
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/simd_lane_op.sv
// Single-lane combinational op + signed-overflow logic.
// Define SIMD_ALU_SATURATE_EN to clamp MUL/ADD/SUB results on overflow.
module simd_lane_op
    import simd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o
);

    logic signed [2*WIDTH-1:0] a_x, b_x, prod;
    logic        [WIDTH:0]     sum, diff;
    logic                      mul_ovf, add_ovf, sub_ovf;
    logic        [WIDTH-1:0]   mul_r, add_r, sub_r;

    assign a_x  = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_x  = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign prod = a_x * b_x;
    assign sum  = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
    assign diff = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};

    // Product fits iff its upper half plus the result sign bit are all equal.
    assign mul_ovf = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
    assign add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    assign sub_ovf = diff[WIDTH] ^ diff[WIDTH-1];

`ifdef SIMD_ALU_SATURATE_EN
    logic [WIDTH-1:0] smax, smin;
    assign smax  = WIDTH'(sat_max(WIDTH));
    assign smin  = WIDTH'(sat_min(WIDTH));
    assign mul_r = mul_ovf ? (prod[2*WIDTH-1] ? smin : smax) : prod[WIDTH-1:0];
    assign add_r = add_ovf ? (sum[WIDTH]      ? smin : smax) : sum[WIDTH-1:0];
    assign sub_r = sub_ovf ? (diff[WIDTH]     ? smin : smax) : diff[WIDTH-1:0];
`else
    assign mul_r = prod[WIDTH-1:0];
    assign add_r = sum[WIDTH-1:0];
    assign sub_r = diff[WIDTH-1:0];
`endif

    always_comb begin
        res_o = a_i;
        ovf_o = 1'b0;
        if (en_i) begin
            case (alu_op_e'(op_i))
                OP_MUL:  begin res_o = mul_r; ovf_o = mul_ovf; end
                OP_ADD:  begin res_o = add_r; ovf_o = add_ovf; end
                OP_SUB:  begin res_o = sub_r; ovf_o = sub_ovf; end
                OP_MIN:  res_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
                OP_MAX:  res_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
                OP_AND:  res_o = a_i & b_i;
                OP_OR:   res_o = a_i | b_i;
                default: res_o = a_i ^ b_i;
            endcase
        end
    end

endmodule

// File: rtl/simd_lane_alu.sv
// LANES x WIDTH SIMD integer ALU, two-stage pipeline with valid/ready handshake.
// Define SIMD_ALU_SATURATE_EN for saturating MUL/ADD/SUB.
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [LANES-1:0]       in_mask,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_res,
    output logic [LANES-1:0]       out_ovf
);

    localparam int STAGES = 2;

    logic [STAGES:1]                  vld_pipe_q;
    logic                             advance;
    logic [OP_W-1:0]                  op_q;
    logic [LANES-1:0]                 mask_q;
    logic [LANES-1:0][WIDTH-1:0]      a_q, b_q;
    logic [LANES-1:0][WIDTH-1:0]      res_d, res_q;
    logic [LANES-1:0]                 ovf_d, ovf_q;

    // The whole pipe moves in lockstep; a stalled output freezes both stages.
    assign advance   = !vld_pipe_q[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe_q[STAGES];
    assign out_res   = res_q;
    assign out_ovf   = ovf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_q <= '0;
            op_q       <= '0;
            mask_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            ovf_q      <= '0;
        end else if (advance) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
            op_q       <= in_op;
            mask_q     <= in_mask;
            a_q        <= in_a;
            b_q        <= in_b;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        simd_lane_op #(.WIDTH(WIDTH)) u_lane (
            .op_i  (op_q),
            .en_i  (mask_q[g]),
            .a_i   (a_q[g]),
            .b_i   (b_q[g]),
            .res_o (res_d[g]),
            .ovf_o (ovf_d[g])
        );
    end

endmodule

// File: tb/tb_simd_lane_alu.sv
// Self-checking bench for simd_lane_alu: vector table, stall/reset sequences, random vs model.
module tb_simd_lane_alu;

    localparam int L = 4;
    localparam int W = 32;
`ifdef SIMD_ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [2:0]       in_op;
    logic [L-1:0]     in_mask, out_ovf;
    logic [L*W-1:0]   in_a, in_b, out_res;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simd_lane_alu #(.LANES(L), .WIDTH(W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_mask(in_mask), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_ovf(out_ovf)
    );

    typedef struct {
        logic [2:0]     op;
        logic [L-1:0]   mask;
        logic [L*W-1:0] a, b, res;
        logic [L-1:0]   ovf;
    } vec_t;

    typedef struct {
        logic [L*W-1:0] res;
        logic [L-1:0]   ovf;
    } exp_t;

    vec_t tab[8];
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_op    = v.op;
        in_mask  = v.mask;
        in_a     = v.a;
        in_b     = v.b;
    endtask

    // Reference: plain signed arithmetic on 64-bit integers, then range test.
    function automatic void model(input logic [2:0] op, input logic [L-1:0] m,
                                  input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                  output logic [L*W-1:0] r, output logic [L-1:0] o);
        longint mx, mn, sa, sb, rr;
        mx = (longint'(1) <<< (W-1)) - 1;
        mn = -mx - 1;
        for (int i = 0; i < L; i++) begin
            sa = longint'($signed(a[i*W +: W]));
            sb = longint'($signed(b[i*W +: W]));
            case (op)
                3'd0: rr = sa * sb;
                3'd1: rr = sa + sb;
                3'd2: rr = sa - sb;
                3'd3: rr = (sa < sb) ? sa : sb;
                3'd4: rr = (sa > sb) ? sa : sb;
                3'd5: rr = sa & sb;
                3'd6: rr = sa | sb;
                default: rr = sa ^ sb;
            endcase
            o[i] = (op <= 3'd2) && (rr > mx || rr < mn);
            if (SAT && o[i]) rr = (rr > mx) ? mx : mn;
            r[i*W +: W] = rr[W-1:0];
            if (!m[i]) begin
                r[i*W +: W] = a[i*W +: W];
                o[i] = 1'b0;
            end
        end
    endfunction

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int n_in, n_out, cyc;
        logic hold_pend;
        logic [L*W-1:0] hold_res, er;
        logic [L-1:0] hold_ovf, eo;
        exp_t e;

        // lane 0 is the rightmost word in each concatenation
        tab[0] = '{3'd1, 4'b1111, {32'd10, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'd1},
                   {32'hFFFF_FFEC, 32'd5, 32'd1, 32'd2},
                   {32'hFFFF_FFF6, 32'd0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 32'd3}, 4'b0010};
        tab[1] = '{3'd0, 4'b0111, {32'd7, 32'hFFFF_FFFC, 32'h0001_0000, 32'd3},
                   {32'd0, 32'hFFFF_FFFC, 32'h0001_0000, 32'hFFFF_FFFE},
                   {32'd7, 32'd16, SAT ? 32'h7FFF_FFFF : 32'd0, 32'hFFFF_FFFA}, 4'b0010};
        tab[2] = '{3'd3, 4'b1111, {32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF},
                   {32'd3, 32'd1, 32'd0, 32'h8000_0000},
                   {32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000}, 4'b0000};
        tab[3] = '{3'd4, 4'b1111, {32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF},
                   {32'd3, 32'd1, 32'd0, 32'h8000_0000},
                   {32'd5, 32'd1, 32'd0, 32'h7FFF_FFFF}, 4'b0000};
        tab[4] = '{3'd5, 4'b1011, {32'hFFFF_0000, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0000_FFFF},
                   {32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h5555_5555, 32'hFFFF_0000},
                   {32'h0F0F_0000, 32'h1234_5678, 32'd0, 32'd0}, 4'b0000};
        tab[5] = '{3'd6, 4'b1111, {32'hFFFF_0000, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0000_FFFF},
                   {32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h5555_5555, 32'hFFFF_0000},
                   {32'hFFFF_0F0F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'b0000};
        tab[6] = '{3'd7, 4'b1111, {32'hFFFF_0000, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0000_FFFF},
                   {32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h5555_5555, 32'hFFFF_0000},
                   {32'hF0F0_0F0F, 32'hEDCB_A987, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'b0000};
        tab[7] = '{3'd2, 4'b1111, {32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd10},
                   {32'd1, 32'hFFFF_FFFF, 32'd1, 32'd3},
                   {SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, SAT ? 32'h7FFF_FFFF : 32'h8000_0000,
                    32'hFFFF_FFFF, 32'd7}, 4'b1100};

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_mask = '0; in_a = '0; in_b = '0;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_res", out_res, '0);
        chk("rst_out_ovf", out_ovf, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1 rstn = 1'b1;
        out_ready = 1'b1;

        // Back-to-back table beats: results must appear on consecutive cycles from cycle 2.
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(tab[i]); else in_valid = 1'b0;
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("b2b_valid[%0d]", i - 2), out_valid, 1'b1);
                chk($sformatf("b2b_res[%0d]", i - 2), out_res, tab[i-2].res);
                chk($sformatf("b2b_ovf[%0d]", i - 2), out_ovf, tab[i-2].ovf);
            end else begin
                chk($sformatf("b2b_lat[%0d]", i), out_valid, 1'b0);
            end
            @(posedge clk); #1;
        end

        // Stall with full pipe: hold output, block input, then drain in order.
        out_ready = 1'b0;
        drive(tab[2]); @(posedge clk); #1;
        drive(tab[3]); @(posedge clk); #1;
        drive(tab[4]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_valid[%0d]", k), out_valid, 1'b1);
            chk($sformatf("stall_in_ready[%0d]", k), in_ready, 1'b0);
            chk($sformatf("stall_res[%0d]", k), out_res, tab[2].res);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", in_ready, 1'b1);
        chk("drain_res0", out_res, tab[2].res);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("drain_res1", out_res, tab[3].res);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_res2", out_res, tab[4].res);
        chk("drain_ovf2", out_ovf, tab[4].ovf);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_empty", out_valid, 1'b0);

        // Reset with two beats in flight.
        @(posedge clk); #1 drive(tab[0]);
        @(posedge clk); #1 drive(tab[1]);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1'b1);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1 rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid[%0d]", k), out_valid, 1'b0);
            chk($sformatf("post_rst_ready[%0d]", k), in_ready, 1'b1);
        end

        // Random traffic with random backpressure, scoreboard against the model.
        n_in = 0; n_out = 0; cyc = 0; hold_pend = 1'b0;
        hold_res = '0; hold_ovf = '0;
        while (n_in < 10000 && cyc < 50000) begin
            @(posedge clk); #1;
            cyc++;
            in_valid = ($urandom_range(0, 9) < 8);
            in_op    = 3'($urandom_range(0, 7));
            in_mask  = L'($urandom);
            for (int i = 0; i < L; i++) begin
                in_a[i*W +: W] = rnd_word();
                in_b[i*W +: W] = rnd_word();
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_res", out_res, hold_res);
                chk("hold_ovf", out_ovf, hold_ovf);
            end
            if (in_valid && in_ready) begin
                model(in_op, in_mask, in_a, in_b, er, eo);
                e.res = er; e.ovf = eo;
                sbq.push_back(e);
                n_in++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    chk("rand_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chk("rand_res", out_res, e.res);
                    chk("rand_ovf", out_ovf, e.ovf);
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_res  = out_res;
            hold_ovf  = out_ovf;
        end
        chk("rand_budget_beats", n_in, 10000);

        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                n_out++;
                if (sbq.size() == 0) begin
                    chk("drain_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chk("rand_res", out_res, e.res);
                    chk("rand_ovf", out_ovf, e.ovf);
                end
            end
            @(posedge clk); #1;
        end
        chk("count_in_out", n_out, n_in);
        chk("sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
